// File: rtl/bp_meter_pkg.sv
// Shared types and helpers for the band-pass envelope meter.
// Holds the meter FSM state enum and the exact absolute-value helper.
package bp_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ABS_W = 64;

  // Exact magnitude; callers sign-extend into ABS_W and truncate back,
  // so the most negative sample maps to 2^(DATA_W-1) without saturation.
  function automatic logic [ABS_W-1:0] abs_val(
    input logic signed [ABS_W-1:0] x
  );
    return x[ABS_W-1] ? ABS_W'(-x) : ABS_W'(x);
  endfunction

endpackage

// File: rtl/bp_zc_detect.sv
// Rising zero-crossing detector with optional hysteresis.
// Hysteresis arm logic is built only when BP_METER_HYST_EN is defined.
module bp_zc_detect #(
  parameter int DATA_W = 16,
  parameter int HYST   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     crossing
);

  if (HYST < 0) begin : g_bad_hyst
    $error("HYST must be non-negative");
  end

`ifdef BP_METER_HYST_EN

  localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);

  logic arm;
  logic hit_hi;
  logic hit_lo;

  assign hit_hi   = sample >= HYST_POS;
  assign hit_lo   = sample < HYST_NEG;
  assign crossing = valid && arm && hit_hi;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      arm <= 1'b0;
    end else if (crossing) begin
      arm <= 1'b0;
    end else if (valid && hit_lo) begin
      arm <= 1'b1;
    end
  end

`else

  logic have_prev;
  logic prev_neg;

  // have_prev keeps the first sample of a window from counting
  assign crossing = valid && have_prev
                 && prev_neg && !sample[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      have_prev <= 1'b0;
      prev_neg  <= 1'b0;
    end else if (valid) begin
      have_prev <= 1'b1;
      prev_neg  <= sample[DATA_W-1];
    end
  end

`endif

endmodule

// File: rtl/bp_envelope_meter.sv
// Windowed peak / zero-crossing meter on a band-pass filter output.
// Define BP_METER_HYST_EN to enable crossing hysteresis of HYST LSBs.
module bp_envelope_meter
  import bp_meter_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 10,
  parameter int HYST     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [DATA_W-1:0]        peak,
  output logic [WIN_LOG2-1:0]      zc_count,
  output logic                     overrun
);

  localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;
  localparam logic [WIN_LOG2-1:0] ZC_MAX  = '1;

  state_t              state;
  state_t              state_n;
  logic [WIN_LOG2-1:0] sample_cnt;
  logic [DATA_W-1:0]   mag;
  logic                win_start;
  logic                run_valid;
  logic                last_sample;
  logic                done_valid;
  logic                crossing;

  assign win_start   = (state == IDLE) && start;
  assign run_valid   = (state == RUN) && sample_valid;
  assign done_valid  = (state == DONE) && sample_valid;
  assign last_sample = run_valid && (sample_cnt == CNT_MAX);
  assign mag         = DATA_W'(abs_val(ABS_W'(sample)));

  bp_zc_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_zc (
    .clk      (clk),
    .rst      (rst),
    .clear    (win_start),
    .valid    (run_valid),
    .sample   (sample),
    .crossing (crossing)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start)        state_n = RUN;
      RUN:  if (last_sample)  state_n = DONE;
      DONE: if (result_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    unique case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      peak       <= '0;
      zc_count   <= '0;
      overrun    <= 1'b0;
    end else if (win_start) begin
      sample_cnt <= '0;
      peak       <= '0;
      zc_count   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (run_valid) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (mag > peak) peak <= mag;
      end
      // saturate rather than wrap
      if (crossing && zc_count != ZC_MAX) begin
        zc_count <= zc_count + 1'b1;
      end
      if (done_valid) overrun <= 1'b1;
    end
  end

endmodule
